clk_div_gen: RTL

Programmable, glitch-free clock generator that drives the `clk` line of the clock interface consumed by the verification environment. It derives an output clock from the system clock by integer half-period division. Start, stop and re-division requests arrive over a valid/ready config port, and take effect only at a low-phase boundary, so the driven clock never shows runt pulses.

---
 rtl/clk_div_gen.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_gen
//  Purpose  : Programmable glitch-free clock generator. Divides the system
//             clock by an integer half-period. Start / stop / re-division
//             requests arrive on a valid/ready config port and are applied
//             only at the end of a low phase, so the generated clock never
//             shows a shortened high or low pulse.
//  Ports    :
//    clk        in   system clock, all logic on its rising edge
//    rst        in   asynchronous active-high reset
//    cfg_valid  in   config request valid
//    cfg_ready  out  config can be accepted (transfer = valid & ready)
//    cfg_en     in   1 = run, 0 = stop
//    cfg_half   in   half-period in clk cycles (0 treated as 1)
//    clk_out    out  generated clock (registered)
//    clk_rise   out  pulse in the first high cycle of each high phase
//    clk_fall   out  pulse in the first low cycle after a high phase
//    running    out  generator is in RUN_HI or RUN_LO
//    rise_cnt   out  count of generated rising edges, wraps silently
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             cfg_en,
   input  logic [DIV_W-1:0] cfg_half,
   output logic             clk_out,
   output logic             clk_rise,
   output logic             clk_fall,
   output logic             running,
   output logic [CNT_W-1:0] rise_cnt
);

   // -------------------------------------------------------------------------
   // State encoding
   // -------------------------------------------------------------------------
   localparam logic [1:0] ST_STOPPED = 2'd0;
   localparam logic [1:0] ST_RUN_HI  = 2'd1;
   localparam logic [1:0] ST_RUN_LO  = 2'd2;

   localparam logic [DIV_W-1:0] C_HALF_ONE = DIV_W'(1);
   localparam logic [DIV_W-1:0] C_HALF_ZERO = '0;
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   logic [1:0]       r_state;
   logic [DIV_W-1:0] r_cnt;        // remaining cycles of current phase minus one
   logic [DIV_W-1:0] r_half;       // active half-period (always >= 1)
   logic             r_pend_valid;
   logic             r_pend_en;
   logic [DIV_W-1:0] r_pend_half;  // stored already normalised (>= 1)
   logic             r_clk_out;
   logic             r_clk_rise;
   logic             r_clk_fall;
   logic [CNT_W-1:0] r_rise_cnt;

   // -------------------------------------------------------------------------
   // Combinational signals
   // -------------------------------------------------------------------------
   logic             w_cfg_fire;
   logic [DIV_W-1:0] w_cfg_half_norm;
   logic             w_pend_load;
   logic             w_pend_consume;
   logic [1:0]       w_state_nxt;
   logic [DIV_W-1:0] w_cnt_nxt;
   logic [DIV_W-1:0] w_half_nxt;
   logic             w_rise;
   logic             w_fall;

   // While stopped nothing can be pending, so the port is always open. While
   // running, the single pending slot blocks further requests until the
   // low-phase end consumes it.
   assign cfg_ready       = (r_state == ST_STOPPED) || !r_pend_valid;
   assign w_cfg_fire      = cfg_valid && cfg_ready;
   assign w_cfg_half_norm = (cfg_half == C_HALF_ZERO) ? C_HALF_ONE : cfg_half;

   // Requests accepted while running are parked; they are never applied in
   // the cycle they arrive, which also covers the last low cycle: a request
   // accepted there waits for the following low-phase end.
   assign w_pend_load = w_cfg_fire && (r_state != ST_STOPPED);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_half_nxt     = r_half;
      w_rise         = 1'b0;
      w_fall         = 1'b0;
      w_pend_consume = 1'b0;

      case (r_state)
         ST_STOPPED: begin
            if (w_cfg_fire) begin
               w_half_nxt = w_cfg_half_norm;
               if (cfg_en) begin
                  w_state_nxt = ST_RUN_HI;
                  w_cnt_nxt   = w_cfg_half_norm - C_HALF_ONE;
                  w_rise      = 1'b1;
               end
            end
         end

         ST_RUN_HI: begin
            // A high phase always runs to completion; config is not looked at.
            if (r_cnt == C_HALF_ZERO) begin
               w_state_nxt = ST_RUN_LO;
               w_cnt_nxt   = r_half - C_HALF_ONE;
               w_fall      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - C_HALF_ONE;
            end
         end

         ST_RUN_LO: begin
            if (r_cnt == C_HALF_ZERO) begin
               // Low-phase end is the only point where config takes effect.
               if (r_pend_valid) begin
                  w_pend_consume = 1'b1;
                  w_half_nxt     = r_pend_half;
                  if (r_pend_en) begin
                     w_state_nxt = ST_RUN_HI;
                     w_cnt_nxt   = r_pend_half - C_HALF_ONE;
                     w_rise      = 1'b1;
                  end else begin
                     // Stopping here leaves clk_out low: no partial pulse.
                     w_state_nxt = ST_STOPPED;
                     w_cnt_nxt   = C_HALF_ZERO;
                  end
               end else begin
                  w_state_nxt = ST_RUN_HI;
                  w_cnt_nxt   = r_half - C_HALF_ONE;
                  w_rise      = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - C_HALF_ONE;
            end
         end

         default: begin
            // Unused encoding: park safely with the clock low.
            w_state_nxt = ST_STOPPED;
            w_cnt_nxt   = C_HALF_ZERO;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM, phase counter and active half-period
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_STOPPED;
         r_cnt   <= C_HALF_ZERO;
         r_half  <= C_HALF_ONE;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_half  <= w_half_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Pending config slot
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_valid <= 1'b0;
         r_pend_en    <= 1'b0;
         r_pend_half  <= C_HALF_ONE;
      end else begin
         // Consume and load never coincide: ready is low while the slot is
         // full, and consumption only happens with the slot full.
         if (w_pend_consume) begin
            r_pend_valid <= 1'b0;
         end
         if (w_pend_load) begin
            r_pend_valid <= 1'b1;
            r_pend_en    <= cfg_en;
            r_pend_half  <= w_cfg_half_norm;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Registered outputs: clk_out comes straight from a flop so the generated
   // clock cannot glitch on state decode.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_out  <= 1'b0;
         r_clk_rise <= 1'b0;
         r_clk_fall <= 1'b0;
         r_rise_cnt <= '0;
      end else begin
         r_clk_out  <= (w_state_nxt == ST_RUN_HI);
         r_clk_rise <= w_rise;
         r_clk_fall <= w_fall;
         // Count updates on the same edge that raises clk_rise, so the new
         // value is visible in the cycle the pulse is.
         if (w_rise) begin
            r_rise_cnt <= r_rise_cnt + C_CNT_ONE;
         end
      end
   end

   assign clk_out  = r_clk_out;
   assign clk_rise = r_clk_rise;
   assign clk_fall = r_clk_fall;
   assign rise_cnt = r_rise_cnt;
   assign running  = (r_state == ST_RUN_HI) || (r_state == ST_RUN_LO);

endmodule
`default_nettype wire
